// File: rtl/data_mem_responder_if.sv
// Request / store-data / response channels between the mem-access stage and the data memory.
interface data_mem_responder_if;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned LEN_W  = 3;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [15:0]       req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              wd_valid;
    logic              wd_ready;
    logic [DATA_W-1:0] wd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_last;
    logic              busy;

    modport master (
        output req_valid, req_write, req_addr, req_len, wd_valid, wd_data, rsp_ready,
        input  req_ready, wd_ready, rsp_valid, rsp_rdata, rsp_last, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_len, wd_valid, wd_data, rsp_ready,
        output req_ready, wd_ready, rsp_valid, rsp_rdata, rsp_last, busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// Burst data-memory responder: accepts load/store bursts of 1..8 words, inserts fixed
// wait states, streams load data or collects store data, and acknowledges stores.
module data_mem_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    data_mem_responder_if.slave bus
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned LEN_W  = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_WRITE, S_ACK} state_t;

    typedef struct packed {
        logic req_ready;
        logic wd_ready;
        logic rsp_valid;
        logic busy;
    } flags_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    flags_t            flags;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [LEN_W-1:0]  beat_cnt;
    logic [LEN_W-1:0]  next_beat;
    logic [LEN_W-1:0]  len_q;
    logic              write_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic              rsp_last_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [ADDR_W-1:0] req_word;
    logic              unused_addr_bits;

    // Handshake flags are a pure function of the state being entered.
    function automatic flags_t flags_for(input state_t s);
        flags_t f;
        f.req_ready = (s == S_IDLE);
        f.wd_ready  = (s == S_WRITE);
        f.rsp_valid = (s == S_READ) || (s == S_ACK);
        f.busy      = (s != S_IDLE);
        return f;
    endfunction

    assign req_word         = bus.req_addr[ADDR_W-1:0];
    assign unused_addr_bits = ^bus.req_addr;
    assign next_addr        = cur_addr + ADDR_W'(1);
    assign next_beat        = beat_cnt + LEN_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            flags       <= flags_for(S_IDLE);
            rsp_last_q  <= 1'b0;
            rsp_rdata_q <= '0;
            cur_addr    <= '0;
            beat_cnt    <= '0;
            wait_cnt    <= '0;
            len_q       <= '0;
            write_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        cur_addr <= req_word;
                        write_q  <= bus.req_write;
                        len_q    <= bus.req_len;
                        beat_cnt <= '0;
                        wait_cnt <= '0;
                        if (WAIT_CYCLES != 0) begin
                            state <= S_WAIT;
                            flags <= flags_for(S_WAIT);
                        end else if (bus.req_write) begin
                            state <= S_WRITE;
                            flags <= flags_for(S_WRITE);
                        end else begin
                            state       <= S_READ;
                            flags       <= flags_for(S_READ);
                            rsp_rdata_q <= mem[req_word];
                            rsp_last_q  <= (bus.req_len == '0);
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == CNT_W'(WAIT_CYCLES - 1)) begin
                        if (write_q) begin
                            state <= S_WRITE;
                            flags <= flags_for(S_WRITE);
                        end else begin
                            state       <= S_READ;
                            flags       <= flags_for(S_READ);
                            rsp_rdata_q <= mem[cur_addr];
                            rsp_last_q  <= (len_q == '0);
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_READ: begin
                    // Data for the next beat is fetched on the same edge the current one is taken.
                    if (bus.rsp_ready) begin
                        cur_addr <= next_addr;
                        beat_cnt <= next_beat;
                        if (beat_cnt == len_q) begin
                            state       <= S_IDLE;
                            flags       <= flags_for(S_IDLE);
                            rsp_last_q  <= 1'b0;
                            rsp_rdata_q <= '0;
                        end else begin
                            rsp_rdata_q <= mem[next_addr];
                            rsp_last_q  <= (next_beat == len_q);
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.wd_valid) begin
                        cur_addr <= next_addr;
                        beat_cnt <= next_beat;
                        if (beat_cnt == len_q) begin
                            state       <= S_ACK;
                            flags       <= flags_for(S_ACK);
                            rsp_last_q  <= 1'b1;
                            rsp_rdata_q <= '0;
                        end
                    end
                end
                S_ACK: begin
                    if (bus.rsp_ready) begin
                        state      <= S_IDLE;
                        flags      <= flags_for(S_IDLE);
                        rsp_last_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    flags      <= flags_for(S_IDLE);
                    rsp_last_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage is never reset; reset only blocks a write on its own edge.
    always_ff @(posedge clk) begin
        if (!reset && state == S_WRITE && bus.wd_valid) begin
            mem[cur_addr] <= bus.wd_data;
        end
    end

    assign bus.req_ready = flags.req_ready;
    assign bus.wd_ready  = flags.wd_ready;
    assign bus.rsp_valid = flags.rsp_valid;
    assign bus.busy      = flags.busy;
    assign bus.rsp_last  = rsp_last_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed table, multi-cycle corner sequences and
// randomized bursts checked against a word-array memory model.
module tb_data_mem_responder;
    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned WAIT_CYCLES = 2;
    localparam int unsigned DEPTH       = 1 << ADDR_W;
    localparam int          TIMEOUT     = 40;

    typedef struct {
        logic [15:0] addr;
        logic [2:0]  len;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
    } vec_t;

    logic clk;
    logic reset;
    data_mem_responder_if bus();

    data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    logic [15:0] model [DEPTH];
    logic [15:0] wbuf  [8];
    vec_t        vecs  [5];
    int          tests;
    int          failed;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int idx(input logic [15:0] a, input int b);
        return int'(ADDR_W'(a + 16'(b)));
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (!bus.req_ready && n < TIMEOUT) begin
            tick();
            n++;
        end
        check("req_ready_before_req", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic check_idle(input string name);
        check({name, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        check({name, "_busy"}, 32'(bus.busy), 32'd0);
        check({name, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic do_store(input logic [15:0] addr, input logic [2:0] len,
                            input int stall_beat, input int stall_n);
        int n;
        wait_idle();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = addr;
        bus.req_len   = len;
        tick();
        bus.req_valid = 1'b0;
        bus.req_addr  = 16'($urandom);
        bus.req_len   = 3'($urandom);
        n = 0;
        while (!bus.wd_ready && n < TIMEOUT) begin
            bus.rsp_ready = 1'($urandom);
            tick();
            n++;
        end
        bus.rsp_ready = 1'b0;
        check("store_wait_cycles", 32'(n), 32'(WAIT_CYCLES));
        for (int b = 0; b <= int'(len); b++) begin
            check("store_wd_ready", 32'(bus.wd_ready), 32'd1);
            if (b == stall_beat) begin
                bus.wd_valid = 1'b0;
                bus.wd_data  = 16'($urandom);
                for (int k = 0; k < stall_n; k++) begin
                    tick();
                    check("store_stall_wd_ready", 32'(bus.wd_ready), 32'd1);
                end
            end
            bus.wd_valid = 1'b1;
            bus.wd_data  = wbuf[b];
            tick();
            model[idx(addr, b)] = wbuf[b];
        end
        bus.wd_valid = 1'b0;
        check("ack_valid", 32'(bus.rsp_valid), 32'd1);
        check("ack_last", 32'(bus.rsp_last), 32'd1);
        check("ack_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("ack_excl", {30'd0, bus.wd_ready, bus.req_ready}, 32'd0);
        if ($urandom_range(1) == 1) begin
            tick();
            check("ack_hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("ack_hold_last", 32'(bus.rsp_last), 32'd1);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check_idle("store_end");
    endtask

    task automatic do_load(input logic [15:0] addr, input logic [2:0] len,
                           input int bp_beat, input int bp_n,
                           output logic [15:0] first, output logic [15:0] last);
        int n;
        logic [15:0] exp;
        wait_idle();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = addr;
        bus.req_len   = len;
        tick();
        bus.req_valid = 1'b0;
        bus.req_addr  = 16'($urandom);
        bus.req_len   = 3'($urandom);
        n = 0;
        while (!bus.rsp_valid && n < TIMEOUT) begin
            bus.wd_valid = 1'($urandom);
            bus.wd_data  = 16'($urandom);
            tick();
            n++;
        end
        bus.wd_valid = 1'b0;
        check("load_latency", 32'(n), 32'(WAIT_CYCLES));
        first = '0;
        last  = '0;
        for (int b = 0; b <= int'(len); b++) begin
            exp = model[idx(addr, b)];
            check("load_valid", 32'(bus.rsp_valid), 32'd1);
            check("load_data", 32'(bus.rsp_rdata), 32'(exp));
            check("load_last", 32'(bus.rsp_last), 32'(b == int'(len)));
            check("load_excl", {30'd0, bus.wd_ready, bus.req_ready}, 32'd0);
            if (b == 0) first = bus.rsp_rdata;
            if (b == int'(len)) last = bus.rsp_rdata;
            if (b == bp_beat) begin
                bus.rsp_ready = 1'b0;
                for (int k = 0; k < bp_n; k++) begin
                    tick();
                    check("bp_valid", 32'(bus.rsp_valid), 32'd1);
                    check("bp_data", 32'(bus.rsp_rdata), 32'(exp));
                    check("bp_last", 32'(bus.rsp_last), 32'(b == int'(len)));
                end
            end
            bus.rsp_ready = 1'b1;
            tick();
        end
        bus.rsp_ready = 1'b0;
        check_idle("load_end");
    endtask

    initial begin
        logic [15:0] f, l;
        int n;
        tests  = 0;
        failed = 0;
        vecs[0] = '{16'h0010, 3'd0, 16'hBEEF, 16'hBEEF};
        vecs[1] = '{16'h00FE, 3'd3, 16'h1111, 16'h4444};
        vecs[2] = '{16'h00FF, 3'd1, 16'h2222, 16'h3333};
        vecs[3] = '{16'hFF00, 3'd1, 16'h3333, 16'h4444};
        vecs[4] = '{16'h0001, 3'd0, 16'h4444, 16'h4444};

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.wd_valid  = 1'b0;
        bus.wd_data   = '0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_wd_ready", 32'(bus.wd_ready), 32'd0);
        check("rst_rsp_last", 32'(bus.rsp_last), 32'd0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        tick();

        // Give every word a known value so later reads never see uninitialised storage.
        for (int base = 0; base < int'(DEPTH); base += 8) begin
            for (int b = 0; b < 8; b++) wbuf[b] = 16'($urandom);
            do_store(16'(base), 3'd7, -1, 0);
        end

        wbuf[0] = 16'hBEEF;
        do_store(16'h0010, 3'd0, -1, 0);
        wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
        do_store(16'h00FE, 3'd3, -1, 0);

        for (int i = 0; i < 5; i++) begin
            do_load(vecs[i].addr, vecs[i].len, -1, 0, f, l);
            check("vec_first", 32'(f), 32'(vecs[i].exp_first));
            check("vec_last", 32'(l), 32'(vecs[i].exp_last));
        end

        // Backpressure on beat 1 of a 3-beat load.
        do_load(16'h00FE, 3'd2, 1, 4, f, l);
        check("bp_first", 32'(f), 32'h1111);
        check("bp_final", 32'(l), 32'h3333);

        // Store stall mid-burst, then read back.
        for (int b = 0; b < 8; b++) wbuf[b] = 16'hC000 + 16'(b);
        do_store(16'h0080, 3'd5, 2, 3);
        do_load(16'h0080, 3'd5, -1, 0, f, l);
        check("stall_rb_last", 32'(l), 32'hC005);

        // Reset after beat 1 of a 6-beat store; beat 2 is presented on the reset edge.
        for (int b = 0; b < 8; b++) wbuf[b] = 16'hA000 + 16'(b);
        wait_idle();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 16'h0040;
        bus.req_len   = 3'd5;
        tick();
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.wd_ready && n < TIMEOUT) begin
            tick();
            n++;
        end
        check("rstmid_wd_ready", 32'(bus.wd_ready), 32'd1);
        bus.wd_valid = 1'b1;
        bus.wd_data  = wbuf[0];
        tick();
        model[16'h40] = wbuf[0];
        bus.wd_data = wbuf[1];
        tick();
        model[16'h41] = wbuf[1];
        bus.wd_data = wbuf[2];
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        bus.wd_valid = 1'b0;
        check("rstmid_req_ready", 32'(bus.req_ready), 32'd1);
        check("rstmid_busy", 32'(bus.busy), 32'd0);
        check("rstmid_wd_ready_low", 32'(bus.wd_ready), 32'd0);
        check("rstmid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rstmid_rsp_last", 32'(bus.rsp_last), 32'd0);
        check("rstmid_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        do_load(16'h0040, 3'd5, -1, 0, f, l);
        check("rstmid_beat0", 32'(f), 32'hA000);

        // req_valid held high across a busy burst: second request waits for a full idle cycle.
        wait_idle();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0010;
        bus.req_len   = 3'd0;
        tick();
        bus.req_addr = 16'h00FE;
        bus.req_len  = 3'd1;
        check("busy_req_ready", 32'(bus.req_ready), 32'd0);
        check("busy_busy", 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.rsp_valid && n < TIMEOUT) begin
            check("busy_wait_req_ready", 32'(bus.req_ready), 32'd0);
            tick();
            n++;
        end
        check("busy_first_latency", 32'(n), 32'(WAIT_CYCLES));
        check("busy_first_data", 32'(bus.rsp_rdata), 32'(model[16'h10]));
        check("busy_first_last", 32'(bus.rsp_last), 32'd1);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("busy_ret_req_ready", 32'(bus.req_ready), 32'd1);
        check("busy_ret_busy", 32'(bus.busy), 32'd0);
        tick();
        bus.req_valid = 1'b0;
        check("busy_second_accepted", 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.rsp_valid && n < TIMEOUT) begin
            tick();
            n++;
        end
        check("busy_second_latency", 32'(n), 32'(WAIT_CYCLES));
        check("busy_second_b0", 32'(bus.rsp_rdata), 32'(model[16'hFE]));
        check("busy_second_b0_last", 32'(bus.rsp_last), 32'd0);
        bus.rsp_ready = 1'b1;
        tick();
        check("busy_second_b1", 32'(bus.rsp_rdata), 32'(model[16'hFF]));
        check("busy_second_b1_last", 32'(bus.rsp_last), 32'd1);
        tick();
        bus.rsp_ready = 1'b0;
        check_idle("busy_end");

        // Randomized bursts against the memory model.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            logic [2:0]  ln;
            int          sb;
            int          sn;
            a  = 16'($urandom);
            ln = 3'($urandom);
            sb = ($urandom_range(2) == 0) ? int'($urandom_range(int'(ln))) : -1;
            sn = int'($urandom_range(3, 1));
            if ($urandom_range(1) == 1) begin
                for (int b = 0; b < 8; b++) wbuf[b] = 16'($urandom);
                do_store(a, ln, sb, sn);
            end else begin
                do_load(a, ln, sb, sn, f, l);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
